service_display_arbiter: RTL and testbench

//  Grants one of four clock services the shared 4-digit 7-seg display and the 5 push buttons.

---
 rtl/service_display_arbiter_pkg.sv | 34 +++
 rtl/service_display_arbiter_digit_scan.sv | 52 +++++
 rtl/service_display_arbiter.sv | 147 ++++++++++++++
 tb/tb_service_display_arbiter.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/service_display_arbiter_pkg.sv
// Purpose: shared service encodings, FSM states and helpers for the display arbiter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package svc_pkg;

    // One-hot service codes; bit3 is service 1, bit0 is service 4.
    localparam logic [3:0] SVC1     = 4'b1000;
    localparam logic [3:0] SVC2     = 4'b0100;
    localparam logic [3:0] SVC3     = 4'b0010;
    localparam logic [3:0] SVC4     = 4'b0001;
    localparam logic [3:0] SVC_NONE = 4'b0000;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SETTLE = 2'd1,
        S_ACTIVE = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    function automatic logic is_onehot4(input logic [3:0] v);
        return (v != 4'b0000) && ((v & (v - 4'd1)) == 4'b0000);
    endfunction

    // Bit position of a one-hot service code; 0 for anything else.
    function automatic logic [1:0] onehot_idx(input logic [3:0] v);
        case (v)
            SVC3:    return 2'd1;
            SVC2:    return 2'd2;
            SVC1:    return 2'd3;
            default: return 2'd0;
        endcase
    endfunction

endpackage

// File: rtl/service_display_arbiter_digit_scan.sv
// Purpose: free-running digit-scan timebase with blink phase and slot->anode decode.
// Latency: slot/anode/blink_ph are direct decodes of registered counters (0 cycles).
// Backpressure: none; runs continuously in every arbiter state.
//
// Ports:
//   clk, reset  : clock and synchronous active-high reset
//   slot        : current digit slot 0..3 (0 = rightmost digit)
//   blink_ph    : blink phase, toggles every BLINK_DIV full scan rounds
//   wrap        : high on the last cycle of a scan round
//   slot_anode  : active-low anode pattern for the current slot
module digit_scan #(
    parameter int SCAN_DIV  = 16384,
    parameter int BLINK_DIV = 8
) (
    input  logic       clk,
    input  logic       reset,
    output logic [1:0] slot,
    output logic       blink_ph,
    output logic       wrap,
    output logic [3:0] slot_anode
);

    localparam int CW = $clog2(4 * SCAN_DIV);
    localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

    logic [CW-1:0] scan_cnt;
    logic [BW-1:0] round_cnt;

    // SCAN_DIV is a power of two, so the slot is simply the top two bits.
    assign slot       = scan_cnt[CW-1 -: 2];
    assign wrap       = (scan_cnt == CW'(4 * SCAN_DIV - 1));
    assign slot_anode = ~(4'b0001 << slot);

    always_ff @(posedge clk) begin
        if (reset) begin
            scan_cnt  <= '0;
            round_cnt <= '0;
            blink_ph  <= 1'b0;
        end else begin
            scan_cnt <= wrap ? '0 : scan_cnt + CW'(1);
            if (wrap) begin
                if (round_cnt == BW'(BLINK_DIV - 1)) begin
                    round_cnt <= '0;
                    blink_ph  <= ~blink_ph;
                end else begin
                    round_cnt <= round_cnt + BW'(1);
                end
            end
        end
    end

endmodule

// File: rtl/service_display_arbiter.sv
// Purpose: grants one of four services the shared 7-seg display and push buttons.
// Latency: grant/svc_led/push_gnt registered with the FSM transition; anode/digit 1 cycle behind state.
// Backpressure: none; a grant is only issued after svc_sw is one-hot and stable.
//
// Ports:
//   clk, reset : clock and synchronous active-high reset
//   svc_sw     : service select switches (bit3 = svc1 .. bit0 = svc4)
//   finish     : per-service done indication, only the granted bit matters
//   push       : raw buttons {m,r,l,d,u}
//   disp_word  : 4 x 16-bit digit words, service bit i at [16*i +: 16]
//   edit_sel   : 4 x 4-bit one-hot edit-digit masks, same indexing
//   grant      : one-hot granted service, 0 when none
//   push_gnt   : push passed through only while a service is active
//   svc_led    : service LEDs, equal to grant while active
//   anode      : active-low digit enables
//   digit      : BCD nibble for the enabled digit
module service_display_arbiter
    import svc_pkg::*;
#(
    parameter int SCAN_DIV      = 16384,
    parameter int BLINK_DIV     = 8,
    parameter int SETTLE_CYCLES = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  svc_sw,
    input  logic [3:0]  finish,
    input  logic [4:0]  push,
    input  logic [63:0] disp_word,
    input  logic [15:0] edit_sel,
    output logic [3:0]  grant,
    output logic [4:0]  push_gnt,
    output logic [3:0]  svc_led,
    output logic [3:0]  anode,
    output logic [3:0]  digit
);

    localparam int STW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

    state_t         state;
    logic [3:0]     cand;
    logic [STW-1:0] settle_cnt;

    logic [1:0]     slot;
    logic           blink_ph;
    logic [3:0]     slot_anode;
    // The round-end strobe is available from the scanner but the arbiter
    // only needs the slot and blink phase.
    logic           scan_wrap_unused;

    digit_scan #(
        .SCAN_DIV  (SCAN_DIV),
        .BLINK_DIV (BLINK_DIV)
    ) u_digit_scan (
        .clk        (clk),
        .reset      (reset),
        .slot       (slot),
        .blink_ph   (blink_ph),
        .wrap       (scan_wrap_unused),
        .slot_anode (slot_anode)
    );

    // Arbiter FSM. grant, svc_led and push_gnt are written together with the
    // state so they change on the same edge as the transition.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= S_IDLE;
            cand       <= SVC_NONE;
            settle_cnt <= '0;
            grant      <= SVC_NONE;
            svc_led    <= SVC_NONE;
            push_gnt   <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    grant    <= SVC_NONE;
                    svc_led  <= SVC_NONE;
                    push_gnt <= '0;
                    if (is_onehot4(svc_sw)) begin
                        state      <= S_SETTLE;
                        settle_cnt <= '0;
                        cand       <= svc_sw;
                    end
                end
                S_SETTLE: begin
                    if (svc_sw != cand) begin
                        state <= S_IDLE;
                    end else if (settle_cnt == STW'(SETTLE_CYCLES - 1)) begin
                        state    <= S_ACTIVE;
                        grant    <= cand;
                        svc_led  <= cand;
                        push_gnt <= push;
                    end else begin
                        settle_cnt <= settle_cnt + STW'(1);
                    end
                end
                S_ACTIVE: begin
                    // A switch change outranks a finish in the same cycle.
                    if (svc_sw != grant) begin
                        state    <= S_IDLE;
                        grant    <= SVC_NONE;
                        svc_led  <= SVC_NONE;
                        push_gnt <= '0;
                    end else if ((finish & grant) != 4'b0000) begin
                        state    <= S_DONE;
                        grant    <= SVC_NONE;
                        svc_led  <= SVC_NONE;
                        push_gnt <= '0;
                    end else begin
                        push_gnt <= push;
                    end
                end
                S_DONE: begin
                    // The finished service must be deselected before it can run again.
                    if (svc_sw != cand) begin
                        state <= S_IDLE;
                    end
                end
                default: begin
                    state    <= S_IDLE;
                    grant    <= SVC_NONE;
                    svc_led  <= SVC_NONE;
                    push_gnt <= '0;
                end
            endcase
        end
    end

    // {service index, slot} addresses both the edit mask bit and the nibble.
    logic [3:0] sel_idx;
    assign sel_idx = {onehot_idx(grant), slot};

    // anode and digit are registered together so they never disagree.
    always_ff @(posedge clk) begin
        if (reset) begin
            anode <= 4'b1111;
            digit <= 4'h0;
        end else if (state == S_ACTIVE) begin
            anode <= (edit_sel[sel_idx] && !blink_ph) ? 4'b1111 : slot_anode;
            digit <= disp_word[{sel_idx, 2'b00} +: 4];
        end else begin
            anode <= 4'b1111;
            digit <= 4'h0;
        end
    end

endmodule

// File: tb/tb_service_display_arbiter.sv
module tb_service_display_arbiter;

    localparam int SCAN_DIV      = 2;
    localparam int BLINK_DIV     = 2;
    localparam int SETTLE_CYCLES = 3;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  svc_sw;
    logic [3:0]  finish;
    logic [4:0]  push;
    logic [63:0] disp_word;
    logic [15:0] edit_sel;
    logic [3:0]  grant;
    logic [4:0]  push_gnt;
    logic [3:0]  svc_led;
    logic [3:0]  anode;
    logic [3:0]  digit;

    int checks = 0;
    int errors = 0;
    int cyc;

    service_display_arbiter #(
        .SCAN_DIV      (SCAN_DIV),
        .BLINK_DIV     (BLINK_DIV),
        .SETTLE_CYCLES (SETTLE_CYCLES)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .svc_sw    (svc_sw),
        .finish    (finish),
        .push      (push),
        .disp_word (disp_word),
        .edit_sel  (edit_sel),
        .grant     (grant),
        .push_gnt  (push_gnt),
        .svc_led   (svc_led),
        .anode     (anode),
        .digit     (digit)
    );

    always #5 clk = ~clk;

    // Edges seen since reset was last released.
    always @(posedge clk) begin
        if (reset) cyc <= 0;
        else       cyc <= cyc + 1;
    end

    typedef struct {
        logic [3:0] sw;
        logic [3:0] fin;
        logic [4:0] psh;
        logic [3:0] g;
        logic [3:0] led;
        logic [4:0] pg;
        bit         off;   // display must be dark and digit 0 after this edge
    } vec_t;

    vec_t vq[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference scan model: after edge n the outputs reflect the scan counter
    // as it was before that edge, i.e. (n-1) edges after reset release.
    task automatic check_scan(input string name, input int ncyc,
                              input logic [15:0] word, input logic [3:0] esel);
        int n, s, bl;
        logic [3:0] exp_an;
        logic [3:0] exp_dig;
        for (int i = 0; i < ncyc; i++) begin
            tick();
            n  = cyc;
            s  = ((n - 1) % (4 * SCAN_DIV)) / SCAN_DIV;
            bl = ((n - 1) / (4 * SCAN_DIV * BLINK_DIV)) % 2;
            exp_an  = (esel[s] && bl == 0) ? 4'b1111 : ~(4'b0001 << s);
            exp_dig = word[s*4 +: 4];
            chk({name, "_anode"}, anode, exp_an);
            chk({name, "_digit"}, digit, exp_dig);
        end
    endtask

    initial begin
        // sw, fin, push, grant, led, push_gnt, off
        vq.push_back('{4'b1000, 4'b0000, 5'b00000, 4'b0000, 4'b0000, 5'b00000, 1}); // 1 settle starts
        vq.push_back('{4'b1000, 4'b0000, 5'b00000, 4'b0000, 4'b0000, 5'b00000, 1});
        vq.push_back('{4'b1000, 4'b0000, 5'b00000, 4'b0000, 4'b0000, 5'b00000, 1});
        vq.push_back('{4'b1000, 4'b0000, 5'b00000, 4'b1000, 4'b1000, 5'b00000, 1}); // 4 grant
        vq.push_back('{4'b1000, 4'b0000, 5'b10000, 4'b1000, 4'b1000, 5'b10000, 0}); // push passes
        vq.push_back('{4'b1000, 4'b0000, 5'b00000, 4'b1000, 4'b1000, 5'b00000, 0});
        vq.push_back('{4'b1000, 4'b0001, 5'b00000, 4'b1000, 4'b1000, 5'b00000, 0}); // foreign finish
        vq.push_back('{4'b1000, 4'b1000, 5'b01000, 4'b0000, 4'b0000, 5'b00000, 0}); // finish -> DONE
        vq.push_back('{4'b1000, 4'b0000, 5'b01000, 4'b0000, 4'b0000, 5'b00000, 1}); // DONE holds
        vq.push_back('{4'b1000, 4'b1000, 5'b00000, 4'b0000, 4'b0000, 5'b00000, 1});
        vq.push_back('{4'b0000, 4'b0000, 5'b00000, 4'b0000, 4'b0000, 5'b00000, 1}); // 11 -> IDLE
        vq.push_back('{4'b0100, 4'b0000, 5'b00000, 4'b0000, 4'b0000, 5'b00000, 1}); // bounce
        vq.push_back('{4'b0000, 4'b0000, 5'b00000, 4'b0000, 4'b0000, 5'b00000, 1});
        vq.push_back('{4'b0100, 4'b0000, 5'b00000, 4'b0000, 4'b0000, 5'b00000, 1});
        vq.push_back('{4'b0000, 4'b0000, 5'b00000, 4'b0000, 4'b0000, 5'b00000, 1});
        vq.push_back('{4'b0100, 4'b0000, 5'b00000, 4'b0000, 4'b0000, 5'b00000, 1}); // 16 hold
        vq.push_back('{4'b0100, 4'b0000, 5'b00000, 4'b0000, 4'b0000, 5'b00000, 1});
        vq.push_back('{4'b0100, 4'b0000, 5'b00000, 4'b0000, 4'b0000, 5'b00000, 1});
        vq.push_back('{4'b0100, 4'b0000, 5'b00000, 4'b0100, 4'b0100, 5'b00000, 1}); // 19 grant
        vq.push_back('{4'b0010, 4'b0100, 5'b00000, 4'b0000, 4'b0000, 5'b00000, 0}); // switch beats finish
        vq.push_back('{4'b0010, 4'b0000, 5'b00000, 4'b0000, 4'b0000, 5'b00000, 1}); // IDLE -> SETTLE
        vq.push_back('{4'b0010, 4'b0000, 5'b00000, 4'b0000, 4'b0000, 5'b00000, 1});
        vq.push_back('{4'b0010, 4'b0000, 5'b00000, 4'b0000, 4'b0000, 5'b00000, 1});
        vq.push_back('{4'b0010, 4'b0000, 5'b00000, 4'b0010, 4'b0010, 5'b00000, 1}); // 24 grant
        vq.push_back('{4'b1100, 4'b0000, 5'b10000, 4'b0000, 4'b0000, 5'b00000, 0}); // multi-hot
        vq.push_back('{4'b1100, 4'b0000, 5'b10000, 4'b0000, 4'b0000, 5'b00000, 1});
        vq.push_back('{4'b1100, 4'b0000, 5'b00000, 4'b0000, 4'b0000, 5'b00000, 1});

        reset     = 1'b1;
        svc_sw    = 4'b1000;
        finish    = 4'b0000;
        push      = 5'b00000;
        disp_word = {16'h1234, 16'h9abc, 16'h5678, 16'hdef0};
        edit_sel  = {4'b0000, 4'b1111, 4'b0100, 4'b0010};

        // T1: reset state
        repeat (2) tick();
        chk("rst_grant", grant, 4'b0000);
        chk("rst_led", svc_led, 4'b0000);
        chk("rst_anode", anode, 4'b1111);
        chk("rst_digit", digit, 4'h0);
        chk("rst_push_gnt", push_gnt, 5'b00000);
        reset = 1'b0;

        // T1/T2/T5/T6 control-path vectors
        for (int i = 0; i < vq.size(); i++) begin
            svc_sw = vq[i].sw;
            finish = vq[i].fin;
            push   = vq[i].psh;
            tick();
            chk($sformatf("vec%0d_grant", i + 1), grant, vq[i].g);
            chk($sformatf("vec%0d_led", i + 1), svc_led, vq[i].led);
            chk($sformatf("vec%0d_push_gnt", i + 1), push_gnt, vq[i].pg);
            if (vq[i].off) begin
                chk($sformatf("vec%0d_anode", i + 1), anode, 4'b1111);
                chk($sformatf("vec%0d_digit", i + 1), digit, 4'h0);
            end
        end
        finish = 4'b0000;
        push   = 5'b00000;

        // T3: scan of service 1 (1234), no edit mask
        svc_sw = 4'b1000;
        repeat (4) tick();
        chk("t3_grant", grant, 4'b1000);
        tick();
        check_scan("t3", 16, 16'h1234, 4'b0000);

        // T4: blink on digit 2 of service 3 (5678)
        svc_sw = 4'b0010;
        tick();
        chk("t4_drop_grant", grant, 4'b0000);
        repeat (4) tick();
        chk("t4_grant", grant, 4'b0010);
        chk("t4_led", svc_led, 4'b0010);
        tick();
        check_scan("t4", 40, 16'h5678, 4'b0100);

        // Reset in the middle of an active grant clears everything, scan included
        push  = 5'b10000;
        reset = 1'b1;
        tick();
        chk("mid_rst_grant", grant, 4'b0000);
        chk("mid_rst_led", svc_led, 4'b0000);
        chk("mid_rst_push_gnt", push_gnt, 5'b00000);
        chk("mid_rst_anode", anode, 4'b1111);
        chk("mid_rst_digit", digit, 4'h0);
        reset = 1'b0;
        push  = 5'b00000;
        repeat (4) tick();
        chk("post_rst_grant", grant, 4'b0010);
        tick();
        check_scan("post_rst", 12, 16'h5678, 4'b0100);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
